// File: rtl/hdsiso_pkg.sv
// hdsiso_pkg: shared definitions for the hdsiso8 SISO phase sequencer.
//   - FSM state encodings.
//   - Johnson-code helpers, written over a fixed maximum width (JW_MAX) with the
//     real width passed as an argument. Callers zero-extend their JW-bit code
//     into jcode_t and keep only the low bits of the result.
package hdsiso_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // Widest Johnson counter the helpers handle; phase index must cover 2*JW_MAX.
  localparam int JW_MAX = 8;
  localparam int PH_MAX = 4;

  typedef logic [JW_MAX-1:0] jcode_t;
  typedef logic [PH_MAX-1:0] phase_t;

  // Ones in the low jw bits.
  function automatic jcode_t jmask(input int jw);
    jcode_t ones;
    ones = '1;
    return ~(ones << jw);
  endfunction

  // Bit jw-1 of the code.
  function automatic logic jmsb(input jcode_t q, input int jw);
    jcode_t t;
    t = q >> (jw - 1);
    return t[0];
  endfunction

  // Shift left, feeding back the inverted MSB at the LSB.
  function automatic jcode_t johnson_next(input jcode_t q, input int jw);
    logic fb;
    fb = ~jmsb(q, jw);
    return ((q << 1) | jcode_t'(fb)) & jmask(jw);
  endfunction

  // A legal Johnson code has at most one place where adjacent bits differ
  // (0..01..1 or 1..10..0) and nothing set above bit jw-1.
  function automatic logic johnson_legal(input jcode_t q, input int jw);
    jcode_t t;
    t = (q ^ (q >> 1)) & (jmask(jw) >> 1);
    return ((t & (t - jcode_t'(1))) == '0) && ((q & ~jmask(jw)) == '0);
  endfunction

  // Phase index: the count of ones on the filling half, 2*jw minus it on the
  // draining half (MSB set). Only meaningful for legal codes.
  function automatic phase_t johnson_to_phase(input jcode_t q, input int jw);
    int cnt;
    cnt = 0;
    for (int i = 0; i < JW_MAX; i++) cnt += int'(q[i]);
    return jmsb(q, jw) ? phase_t'(2 * jw - cnt) : phase_t'(cnt);
  endfunction

endpackage

// File: rtl/johnson_counter.sv
// johnson_counter: JW-bit Johnson counter with illegal-code recovery.
//   CLK    in   clock
//   RESET  in   async active-low reset
//   ADV    in   advance one phase this cycle
//   Q      out  JW  current code
//   WRAP   out  advancing from the last code back to all-zero this cycle
// An illegal code is cleared on the next edge whether or not ADV is high.
module johnson_counter
  import hdsiso_pkg::*;
#(
  parameter int JW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ADV,
  output logic [JW-1:0] Q,
  output logic          WRAP
);

  localparam logic [JW-1:0] LAST = {1'b1, {(JW-1){1'b0}}};

  logic [JW-1:0] q;
  jcode_t        qx, nx;
  logic          legal;
  logic          unused_nx;

  assign qx    = jcode_t'(q);
  assign nx    = johnson_next(qx, JW);
  assign legal = johnson_legal(qx, JW);
  // Bits above JW are always zero; fold them so the full result is referenced.
  assign unused_nx = ^nx;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      q <= '0;
    else if (!legal) q <= '0;
    else if (ADV)    q <= nx[JW-1:0];
  end

  assign Q    = q;
  assign WRAP = ADV & legal & (q == LAST);

endmodule

// File: rtl/siso_phase_ctrl.sv
// siso_phase_ctrl: phase sequencer for the latch-based SISO shift register.
// One Johnson lap (2*JW clocks) fires every stage enable once, last stage first,
// shifting the register by one bit. Laps are never truncated.
//   CLK         in   clock
//   RESET       in   async active-low reset
//   ENABLE      in   run request (level)
//   FLUSH       in   clear request (level); wins over ENABLE
//   JOHNSON     out  JW      Johnson state
//   PULSES      out  STAGES  registered one-hot stage enables, zero when idle
//   DIN_STROBE  out  stage 0 enable (SISO_in captured)
//   BIT_TICK    out  one cycle after each completed lap
//   DOUT_VALID  out  FILL == STAGES
//   BUSY        out  RUN or STOPPING
//   FILL        out  FILL_W  valid bits held, saturates at STAGES
// JW must be 2..JW_MAX; 2^FILL_W must exceed 2*JW.
module siso_phase_ctrl
  import hdsiso_pkg::*;
#(
  parameter int JW     = 4,
  parameter int FILL_W = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ENABLE,
  input  logic                FLUSH,
  output logic [JW-1:0]       JOHNSON,
  output logic [2*JW-1:0]     PULSES,
  output logic                DIN_STROBE,
  output logic                BIT_TICK,
  output logic                DOUT_VALID,
  output logic                BUSY,
  output logic [FILL_W-1:0]   FILL
);

  localparam int STAGES = 2 * JW;
  localparam int PH_W   = $clog2(STAGES);
  localparam logic [FILL_W-1:0] STAGES_F = FILL_W'(STAGES);

  logic [1:0]        state, state_d;
  logic              busy, wrap, j_legal, lap_done, flush_pend;
  phase_t            ph_full;
  logic [PH_W-1:0]   phase;
  logic [STAGES-1:0] pulses_d;
  logic [FILL_W-1:0] fill_d;
  logic              unused_ph;

  assign busy = (state == ST_RUN) || (state == ST_STOP);

  johnson_counter #(.JW(JW)) u_jc (
    .CLK   (CLK),
    .RESET (RESET),
    .ADV   (busy),
    .Q     (JOHNSON),
    .WRAP  (wrap)
  );

  assign j_legal   = johnson_legal(jcode_t'(JOHNSON), JW);
  assign ph_full   = johnson_to_phase(jcode_t'(JOHNSON), JW);
  assign phase     = ph_full[PH_W-1:0];
  assign unused_ph = ^ph_full;

  // Stage for phase p is STAGES-1-p. An illegal code gets no pulse; the
  // counter clears it on the same edge.
  always_comb begin
    pulses_d = '0;
    for (int i = 0; i < STAGES; i++)
      pulses_d[i] = busy && j_legal && (phase == PH_W'(STAGES - 1 - i));
  end

  // Stage 0 fires in the last phase, so its pulse marks the lap just finished.
  assign lap_done = PULSES[0];

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (ENABLE && !FLUSH) state_d = ST_RUN;
      // On the wrap edge the lap is already whole, so stop straight to IDLE.
      ST_RUN:  if (!ENABLE || FLUSH) state_d = wrap ? ST_IDLE : ST_STOP;
      ST_STOP: if (wrap) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A FLUSH seen mid-lap is remembered so the lap's completion clears instead
  // of incrementing, even if FLUSH has dropped by then.
  always_comb begin
    fill_d = FILL;
    if (lap_done) begin
      if (FLUSH || flush_pend) fill_d = '0;
      else if (FILL != STAGES_F) fill_d = FILL + FILL_W'(1);
    end else if (state == ST_IDLE && FLUSH) begin
      fill_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      PULSES     <= '0;
      FILL       <= '0;
      DOUT_VALID <= 1'b0;
      BIT_TICK   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_d;
      PULSES     <= pulses_d;
      FILL       <= fill_d;
      DOUT_VALID <= (fill_d == STAGES_F);
      BIT_TICK   <= lap_done;
      if (lap_done)          flush_pend <= 1'b0;
      else if (busy && FLUSH) flush_pend <= 1'b1;
    end
  end

  assign BUSY       = busy;
  assign DIN_STROBE = PULSES[0];

endmodule

// File: tb/tb_siso_phase_ctrl.sv
// Directed bench for siso_phase_ctrl: a JW=4 instance (dut_a) and a JW=2
// instance (dut_b) sharing clock and reset.
module tb_siso_phase_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       en_a, fl_a, en_b, fl_b;

  logic [3:0] j_a;  logic [7:0] p_a;  logic [3:0] f_a;
  logic       ds_a, bt_a, dv_a, bz_a;
  logic [1:0] j_b;  logic [3:0] p_b;  logic [2:0] f_b;
  logic       ds_b, bt_b, dv_b, bz_b;

  int         nvec = 0;
  int         nmis = 0;

  logic [3:0] jseq [8];
  logic [7:0] pexp;
  int         ticks;
  logic       found;

  always #5 CLK = ~CLK;

  siso_phase_ctrl #(.JW(4), .FILL_W(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .ENABLE(en_a), .FLUSH(fl_a),
    .JOHNSON(j_a), .PULSES(p_a), .DIN_STROBE(ds_a), .BIT_TICK(bt_a),
    .DOUT_VALID(dv_a), .BUSY(bz_a), .FILL(f_a)
  );

  siso_phase_ctrl #(.JW(2), .FILL_W(3)) dut_b (
    .CLK(CLK), .RESET(RESET), .ENABLE(en_b), .FLUSH(fl_b),
    .JOHNSON(j_b), .PULSES(p_b), .DIN_STROBE(ds_b), .BIT_TICK(bt_b),
    .DOUT_VALID(dv_b), .BUSY(bz_b), .FILL(f_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    jseq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    RESET = 1'b0; en_a = 1'b0; fl_a = 1'b0; en_b = 1'b0; fl_b = 1'b0;
    step(); step();

    // reset state
    chk("rst_j", j_a, 0);   chk("rst_p", p_a, 0);   chk("rst_fill", f_a, 0);
    chk("rst_busy", bz_a, 0); chk("rst_dv", dv_a, 0); chk("rst_tick", bt_a, 0);
    chk("rst_ds", ds_a, 0); chk("rst_b_p", p_b, 0); chk("rst_b_j", j_b, 0);
    @(negedge CLK); RESET = 1'b1;

    // reset mid-lap: pulses drop without waiting for an edge
    en_a = 1'b1;
    step(); step(); step();
    chk("midlap_p", p_a, 8'h40); chk("midlap_j", j_a, 4'h3);
    RESET = 1'b0; #1;
    chk("async_p", p_a, 0); chk("async_j", j_a, 0);
    chk("async_fill", f_a, 0); chk("async_busy", bz_a, 0);
    en_a = 1'b0;
    @(negedge CLK); RESET = 1'b1;

    // single lap from a one-clock ENABLE
    en_a = 1'b1; step(); en_a = 1'b0;
    chk("lap_busy", bz_a, 1); chk("lap_j0", j_a, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      pexp = 8'h80 >> k;
      chk("lap_j", j_a, jseq[(k + 1) % 8]);
      chk("lap_p", p_a, pexp);
      chk("lap_ds", ds_a, k == 7);
    end
    chk("lap_idle", bz_a, 0);
    step();
    chk("lap_tick", bt_a, 1); chk("lap_fill", f_a, 1); chk("lap_p_off", p_a, 0);
    step();
    chk("tick_once", bt_a, 0); chk("lap_fill_hold", f_a, 1);

    // illegal code in IDLE: cleared on the next edge, no pulse, fill kept
    @(negedge CLK);
    force dut_a.u_jc.q = 4'b0101;
    #1;
    release dut_a.u_jc.q;
    step();
    chk("illegal_j", j_a, 0); chk("illegal_p", p_a, 0); chk("illegal_fill", f_a, 1);

    // FLUSH in IDLE
    fl_a = 1'b1; step(); fl_a = 1'b0;
    chk("flush_idle", f_a, 0);

    // fill to saturation over 9 back-to-back laps
    en_a = 1'b1; step();
    ticks = 0;
    for (int c = 0; c < 100 && ticks < 9; c++) begin
      step();
      chk("onehot", $onehot(p_a), 1);
      if (bt_a) begin
        ticks++;
        chk("fill_step", f_a, (ticks > 8) ? 8 : ticks);
        chk("dv_step", dv_a, ticks >= 8);
      end
    end
    chk("fill_ticks", ticks, 9);

    // FLUSH at phase 3 with FILL=8: lap completes, then FILL clears
    found = 1'b0;
    for (int c = 0; c < 16 && !found; c++) begin
      if (j_a == 4'h7) found = 1'b1;
      else step();
    end
    chk("reach_ph3", found, 1);
    chk("pre_flush_fill", f_a, 8); chk("pre_flush_dv", dv_a, 1);
    fl_a = 1'b1; step(); fl_a = 1'b0; en_a = 1'b0;
    chk("flush_busy", bz_a, 1); chk("flush_p", p_a, 8'h10); chk("flush_j", j_a, 4'hF);
    step(); step(); step(); step();
    chk("flush_wrap_busy", bz_a, 0); chk("flush_wrap_j", j_a, 0);
    chk("flush_wrap_p", p_a, 8'h01); chk("flush_wrap_fill", f_a, 8);
    step();
    chk("flush_fill", f_a, 0); chk("flush_dv", dv_a, 0);
    chk("flush_tick", bt_a, 1); chk("flush_idle_end", bz_a, 0);

    // JW=2 instance: four stages, DOUT_VALID after four laps
    en_b = 1'b1; step();
    for (int k = 0; k < 4; k++) begin
      step();
      pexp = 8'h08 >> k;
      chk("b_p", p_b, pexp);
    end
    ticks = 0;
    for (int c = 0; c < 40 && ticks < 4; c++) begin
      if (c > 0) step();
      if (bt_b) begin
        ticks++;
        chk("b_fill", f_b, ticks);
        chk("b_dv", dv_b, ticks == 4);
      end
    end
    chk("b_ticks", ticks, 4);
    en_b = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("b_idle", bz_b, 0); chk("b_fill_sat", f_b, 4); chk("b_dv_hold", dv_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
